// File: rtl/sdram_cmd_arbiter_pkg.sv
// rtl/sdram_cmd_arbiter_pkg.sv - shared command codes and FSM encoding for the SDRAM command arbiter
package sdram_cmd_arbiter_pkg;

  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_WR  = 2'b01;
  localparam logic [1:0] CMD_RDS = 2'b10;
  localparam logic [1:0] CMD_RDL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sdram_cmd_arbiter_if.sv
// rtl/sdram_cmd_arbiter_if.sv - command/beat bus between the arbiter and the SDRAM controller
interface sdram_cmd_arbiter_if #(
  parameter int ADRW = 23
);
  logic [1:0]      sys_cmd;
  logic [ADRW-1:0] sys_addr;
  logic [1:0]      sys_cmd_ack;
  logic            sys_rd_valid;
  logic            sys_wr_valid;

  modport master (
    output sys_cmd, sys_addr,
    input  sys_cmd_ack, sys_rd_valid, sys_wr_valid
  );

  modport slave (
    input  sys_cmd, sys_addr,
    output sys_cmd_ack, sys_rd_valid, sys_wr_valid
  );
endinterface

// File: rtl/sdram_cmd_arbiter_rr_pick.sv
// rtl/sdram_cmd_arbiter_rr_pick.sv - circular priority picker starting at a given channel index
module sdram_cmd_arbiter_rr_pick #(
  parameter  int NCH = 3,
  localparam int IW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  start,
  output logic [NCH-1:0] onehot,
  output logic [IW-1:0]  idx
);

  logic          found;
  logic [IW:0]   pos;

  // pos wraps with a subtract rather than a modulo; start is always < NCH
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = '0;
    for (int i = 0; i < NCH; i++) begin
      pos = {1'b0, start} + (IW+1)'(i);
      if (pos >= (IW+1)'(NCH)) pos = pos - (IW+1)'(NCH);
      if (!found && req[pos[IW-1:0]]) begin
        found               = 1'b1;
        onehot[pos[IW-1:0]] = 1'b1;
        idx                 = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/sdram_cmd_arbiter.sv
// rtl/sdram_cmd_arbiter.sv - N-channel SDRAM command arbiter with burst tracking and beat routing
module sdram_cmd_arbiter
  import sdram_cmd_arbiter_pkg::*;
#(
  parameter int NCH  = 3,
  parameter int ADRW = 23,
  parameter int RR   = 0,
  parameter int LENW = 8,
  parameter logic [LENW*NCH-1:0] BURST = {8'd128, 8'd128, 8'd16}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       req,
  input  logic [2*NCH-1:0]     ch_cmd,
  input  logic [ADRW*NCH-1:0]  ch_addr,
  sdram_cmd_arbiter_if.master  bus,
  output logic [NCH-1:0]       grant,
  output logic [NCH-1:0]       rd_valid,
  output logic [NCH-1:0]       wr_valid,
  output logic [NCH-1:0]       done,
  output logic                 err
);

  localparam int IW = $clog2(NCH);

  arb_state_e      state, state_nxt;
  logic [IW-1:0]   owner, rr_ptr, start;
  logic [LENW-1:0] beat_cnt;

  logic [1:0]      cmd_arr   [NCH];
  logic [ADRW-1:0] addr_arr  [NCH];
  logic [LENW-1:0] burst_arr [NCH];
  logic [NCH-1:0]  cmd_ok;

  logic [NCH-1:0]  raw_oh, eff_oh;
  logic [IW-1:0]   raw_idx, eff_idx;
  logic            eff_valid, bad_cmd, beat, ack_seen, last_beat;

  for (genvar i = 0; i < NCH; i++) begin : g_unpack
    assign cmd_arr[i]   = ch_cmd[2*i +: 2];
    assign addr_arr[i]  = ch_addr[ADRW*i +: ADRW];
    assign burst_arr[i] = BURST[LENW*i +: LENW];
    assign cmd_ok[i]    = (cmd_arr[i] != CMD_NOP);
  end

  assign start = (RR == 0) ? '0 : (rr_ptr == IW'(NCH-1)) ? '0 : rr_ptr + 1'b1;

  // The raw pick only detects an illegal command on the would-be winner;
  // the grant comes from the pick over channels with a legal command.
  sdram_cmd_arbiter_rr_pick #(.NCH(NCH)) u_raw_pick (
    .req    (req),
    .start  (start),
    .onehot (raw_oh),
    .idx    (raw_idx)
  );

  sdram_cmd_arbiter_rr_pick #(.NCH(NCH)) u_eff_pick (
    .req    (req & cmd_ok),
    .start  (start),
    .onehot (eff_oh),
    .idx    (eff_idx)
  );

  assign eff_valid = |eff_oh;
  assign bad_cmd   = (|raw_oh) && (cmd_arr[raw_idx] == CMD_NOP);
  assign beat      = bus.sys_rd_valid | bus.sys_wr_valid;
  assign ack_seen  = (bus.sys_cmd_ack != CMD_NOP);

  assign rd_valid = (state == ST_BUSY) ? (grant & {NCH{bus.sys_rd_valid}}) : '0;
  assign wr_valid = (state == ST_BUSY) ? (grant & {NCH{bus.sys_wr_valid}}) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    last_beat = 1'b0;
    case (state)
      ST_IDLE:  if (eff_valid) state_nxt = ST_ISSUE;
      ST_ISSUE: if (ack_seen)  state_nxt = ST_BUSY;
      ST_BUSY: begin
        if (beat && beat_cnt == LENW'(1)) begin
          last_beat = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.sys_cmd  <= CMD_NOP;
      bus.sys_addr <= '0;
      grant        <= '0;
      owner        <= '0;
      done         <= '0;
      err          <= 1'b0;
      beat_cnt     <= '0;
      rr_ptr       <= IW'(NCH-1);
    end else begin
      done <= '0;
      if ((state == ST_IDLE && bad_cmd) ||
          (state == ST_ISSUE && ack_seen && bus.sys_cmd_ack != bus.sys_cmd) ||
          (state != ST_BUSY && beat))
        err <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (eff_valid) begin
            bus.sys_cmd  <= cmd_arr[eff_idx];
            bus.sys_addr <= addr_arr[eff_idx];
            grant        <= eff_oh;
            owner        <= eff_idx;
            rr_ptr       <= eff_idx;
          end
        end
        ST_ISSUE: begin
          if (ack_seen) begin
            bus.sys_cmd <= CMD_NOP;
            beat_cnt    <= burst_arr[owner];
          end
        end
        ST_BUSY: begin
          if (beat) beat_cnt <= beat_cnt - 1'b1;
          if (last_beat) begin
            done  <= grant;
            grant <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
